// File: rtl/serial_tc_deser.sv
// Deserializer for the LSB-first two's-complement serial stream: re-negates each
// bit on the fly and presents the W-bit word on a valid/ready holding stage.
module serial_tc_deser #(
  parameter int W = 8
) (
  input  logic         t_clk,
  input  logic         r_n,
  input  logic         y_in,
  input  logic         start,
  input  logic         rdy,
  input  logic         clr_ovf,
  output logic [W-1:0] word,
  output logic [W-1:0] raw,
  output logic         vld,
  output logic         maxneg,
  output logic         busy,
  output logic         ovf
);

  // Handshake: a word transfers on any rising edge where vld && rdy; vld, word,
  // raw and maxneg stay stable while vld=1 and rdy=0.

  localparam int CW = $clog2(W);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           seen, seen_nx, seen_eff;
  logic           d, take, done, free;
  logic [W-2:0]   raw_sh, raw_sh_nx, word_sh, word_sh_nx;
  logic [W-1:0]   raw_full, word_full;

  // Shifters keep only the W-1 earlier bits; the current bit completes the word.
  assign raw_full  = {y_in, raw_sh};
  assign word_full = {d, word_sh};
  assign free      = !vld || rdy;
  assign busy      = (state == SHIFT);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    seen_nx    = seen;
    raw_sh_nx  = raw_sh;
    word_sh_nx = word_sh;
    done       = 1'b0;
    seen_eff   = start ? 1'b0 : seen;
    d          = seen_eff ? ~y_in : y_in;
    take       = start || (state == SHIFT);

    if (take) begin
      raw_sh_nx  = raw_full[W-1:1];
      word_sh_nx = word_full[W-1:1];
      seen_nx    = seen_eff | y_in;
    end

    case (state)
      IDLE: begin
        if (start) begin
          cnt_nx   = CW'(1);
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (start) begin
          cnt_nx = CW'(1);
        end else if (cnt == CW'(W-1)) begin
          done     = 1'b1;
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      state   <= IDLE;
      cnt     <= '0;
      seen    <= 1'b0;
      raw_sh  <= '0;
      word_sh <= '0;
      word    <= '0;
      raw     <= '0;
      vld     <= 1'b0;
      maxneg  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      seen    <= seen_nx;
      raw_sh  <= raw_sh_nx;
      word_sh <= word_sh_nx;

      if (done && free) begin
        word   <= word_full;
        raw    <= raw_full;
        maxneg <= (raw_full == {1'b1, {(W-1){1'b0}}});
        vld    <= 1'b1;
      end else if (vld && rdy) begin
        vld <= 1'b0;
      end

      // A dropped frame wins over a simultaneous clear.
      if (done && !free)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

endmodule
